// File: rtl/draw_balls.sv
// Multi-ball circle renderer: 3-stage squared-distance pipeline with per-frame
// double-buffered ball centres, halo flag, lowest-index selection, shading and contact.
module draw_balls #(
  parameter int unsigned N_BALLS     = 2,
  parameter int unsigned CW          = 11,
  parameter int unsigned RADIUS      = 16,
  parameter int unsigned NEAR_MARGIN = 17,
  parameter int unsigned SHADE_SHIFT = 5,
  parameter int unsigned IDW         = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [CW-1:0]         x,
  input  logic [CW-1:0]         y,
  input  logic [N_BALLS*CW-1:0] pos_x,
  input  logic [N_BALLS*CW-1:0] pos_y,
  output logic                  out_valid,
  output logic [N_BALLS-1:0]    in_ball,
  output logic                  near_ball,
  output logic [IDW-1:0]        hit_id,
  output logic [11:0]           ball_color,
  output logic                  contact,
  output logic                  contact_frame
);

  localparam int unsigned P  = CW - 1;
  localparam int unsigned DW = 2 * P + 1;
  localparam int unsigned R2 = RADIUS * RADIUS;
  localparam int unsigned RN = R2 + NEAR_MARGIN;

  logic [CW-1:0] sx [N_BALLS];
  logic [CW-1:0] sy [N_BALLS];

  // Shadow centres; all-ones sets the hidden flag so nothing draws before the first frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_BALLS); i++) begin
        sx[i] <= '1;
        sy[i] <= '1;
      end
    end else if (frame_start) begin
      for (int i = 0; i < int'(N_BALLS); i++) begin
        sx[i] <= pos_x[i*CW +: CW];
        sy[i] <= pos_y[i*CW +: CW];
      end
    end
  end

  logic signed [P:0]    dx_c [N_BALLS];
  logic signed [P:0]    dy_c [N_BALLS];
  logic [N_BALLS-1:0]   vis_c;

  always_comb begin
    vis_c = '0;
    for (int i = 0; i < int'(N_BALLS); i++) begin
      dx_c[i]  = $signed({1'b0, x[P-1:0]}) - $signed({1'b0, sx[i][P-1:0]});
      dy_c[i]  = $signed({1'b0, y[P-1:0]}) - $signed({1'b0, sy[i][P-1:0]});
      vis_c[i] = !x[CW-1] && !y[CW-1] && !sx[i][CW-1] && !sy[i][CW-1];
    end
  end

  logic                 s1_valid;
  logic signed [P:0]    s1_dx [N_BALLS];
  logic signed [P:0]    s1_dy [N_BALLS];
  logic [N_BALLS-1:0]   s1_vis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vis   <= '0;
      for (int i = 0; i < int'(N_BALLS); i++) begin
        s1_dx[i] <= '0;
        s1_dy[i] <= '0;
      end
    end else begin
      s1_valid <= pix_valid;
      s1_vis   <= vis_c;
      for (int i = 0; i < int'(N_BALLS); i++) begin
        s1_dx[i] <= dx_c[i];
        s1_dy[i] <= dy_c[i];
      end
    end
  end

  // Full-width sum of squares; the true value always fits in DW bits
  function automatic logic [DW-1:0] sq_sum(input logic signed [P:0] a,
                                           input logic signed [P:0] b);
    logic signed [DW-1:0] ae;
    logic signed [DW-1:0] be;
    ae = DW'(a);
    be = DW'(b);
    return $unsigned(ae * ae + be * be);
  endfunction

  logic                 s2_valid;
  logic [DW-1:0]        s2_dist [N_BALLS];
  logic [N_BALLS-1:0]   s2_vis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_vis   <= '0;
      for (int i = 0; i < int'(N_BALLS); i++) s2_dist[i] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_vis   <= s1_vis;
      for (int i = 0; i < int'(N_BALLS); i++) s2_dist[i] <= sq_sum(s1_dx[i], s1_dy[i]);
    end
  end

  logic [N_BALLS-1:0] in_c;
  logic               near_c;
  logic [IDW-1:0]     id_c;
  logic [DW-1:0]      wdist_c;
  logic [3:0]         lvl_c;

  // Descending scan so the lowest covering index is the last one written
  always_comb begin
    in_c    = '0;
    near_c  = 1'b0;
    id_c    = '0;
    wdist_c = '0;
    for (int i = int'(N_BALLS) - 1; i >= 0; i--) begin
      in_c[i] = s2_vis[i] && (32'(s2_dist[i]) <= R2);
      if (s2_vis[i] && (32'(s2_dist[i]) <= RN)) near_c = 1'b1;
      if (in_c[i]) begin
        id_c    = IDW'(i);
        wdist_c = s2_dist[i];
      end
    end
    lvl_c = 4'hF - wdist_c[SHADE_SHIFT+3:SHADE_SHIFT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      in_ball    <= '0;
      near_ball  <= 1'b0;
      hit_id     <= '0;
      ball_color <= 12'h000;
    end else if (s2_valid) begin
      out_valid  <= 1'b1;
      in_ball    <= in_c;
      near_ball  <= near_c;
      hit_id     <= id_c;
      ball_color <= (|in_c) ? {3{lvl_c}} : 12'h000;
    end else begin
      out_valid  <= 1'b0;
      in_ball    <= '0;
      near_ball  <= 1'b0;
      hit_id     <= '0;
      ball_color <= 12'h000;
    end
  end

  logic [3:0] pop_c;
  logic       hit3_c;

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(N_BALLS); i++) pop_c = pop_c + 4'(in_ball[i]);
    hit3_c = out_valid && (pop_c >= 4'd2);
  end

  // A hit in the frame_start cycle still belongs to the frame that is ending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contact       <= 1'b0;
      contact_frame <= 1'b0;
    end else if (frame_start) begin
      contact_frame <= contact | hit3_c;
      contact       <= 1'b0;
    end else begin
      contact       <= contact | hit3_c;
    end
  end

endmodule

// File: tb/tb_draw_balls.sv
// Scoreboard bench for draw_balls: a behavioural model predicts each pixel's
// outputs when driven; the monitor compares them when out_valid appears.
module tb_draw_balls;
  localparam int NB  = 2;
  localparam int CW  = 11;
  localparam int IDW = 1;
  localparam int EW  = NB + 1 + IDW + 12;

  logic                clk;
  logic                rst;
  logic                frame_start;
  logic                pix_valid;
  logic [CW-1:0]       x;
  logic [CW-1:0]       y;
  logic [NB*CW-1:0]    pos_x;
  logic [NB*CW-1:0]    pos_y;
  logic                out_valid;
  logic [NB-1:0]       in_ball;
  logic                near_ball;
  logic [IDW-1:0]      hit_id;
  logic [11:0]         ball_color;
  logic                contact;
  logic                contact_frame;

  draw_balls dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y),
    .out_valid(out_valid), .in_ball(in_ball), .near_ball(near_ball),
    .hit_id(hit_id), .ball_color(ball_color),
    .contact(contact), .contact_frame(contact_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] q[$];
  logic [NB*CW-1:0] m_sx;
  logic [NB*CW-1:0] m_sy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model(input int px, input int py);
    logic [NB-1:0]  inb;
    logic           nr;
    logic [IDW-1:0] id;
    logic [11:0]    col;
    int sxv, syv, dx, dy, d;
    bit hid;
    inb = '0; nr = 1'b0; id = '0; col = 12'h000;
    for (int i = NB - 1; i >= 0; i--) begin
      sxv = int'(m_sx[i*CW +: CW]);
      syv = int'(m_sy[i*CW +: CW]);
      hid = (px >= 1024) || (py >= 1024) || (sxv >= 1024) || (syv >= 1024);
      dx  = (px % 1024) - (sxv % 1024);
      dy  = (py % 1024) - (syv % 1024);
      d   = dx * dx + dy * dy;
      if (!hid && d <= 256) begin
        inb[i] = 1'b1;
        id     = IDW'(i);
        col    = {3{4'(15 - ((d >> 5) & 15))}};
      end
      if (!hid && d <= 273) nr = 1'b1;
    end
    return {inb, nr, id, col};
  endfunction

  // Drive one cycle; the prediction uses the shadow in force before this cycle's frame_start
  task automatic cyc(input bit fs, input bit pv, input int px, input int py);
    frame_start = fs;
    pix_valid   = pv;
    x = CW'(px);
    y = CW'(py);
    if (pv) q.push_back(model(px & 2047, py & 2047));
    if (fs) begin
      m_sx = pos_x;
      m_sy = pos_y;
    end
    @(negedge clk);
    frame_start = 1'b0;
    pix_valid   = 1'b0;
  endtask

  task automatic set_ball(input int i, input int px, input int py);
    pos_x[i*CW +: CW] = CW'(px);
    pos_y[i*CW +: CW] = CW'(py);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
      else chk("pixel", 32'({in_ball, near_ball, hit_id, ball_color}), 32'(q.pop_front()));
    end else begin
      chk("bubble", 32'({in_ball, near_ball, hit_id, ball_color}), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; x = '0; y = '0;
    pos_x = '0; pos_y = '0;
    m_sx = '1; m_sy = '1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_contact", 32'(contact), 32'd0);
    chk("rst_contact_frame", 32'(contact_frame), 32'd0);
    rst = 1'b0;

    // Balls hidden after reset; then a frame_start pixel still sees the old shadow
    set_ball(0, 100, 100);
    set_ball(1, 1024 + 500, 500);
    cyc(1'b0, 1'b1, 100, 100);
    cyc(1'b1, 1'b1, 100, 100);
    cyc(1'b0, 1'b1, 100, 100);
    cyc(1'b0, 1'b1, 116, 100);
    cyc(1'b0, 1'b1, 116, 101);
    cyc(1'b0, 1'b1, 117, 100);
    cyc(1'b0, 1'b1, 84, 100);
    cyc(1'b0, 1'b1, 100, 84);
    cyc(1'b0, 1'b1, 1024 + 100, 100);
    cyc(1'b0, 1'b1, 100, 1024 + 100);
    idle(4);

    // Reset with the pipeline full
    cyc(1'b0, 1'b1, 100, 100);
    cyc(1'b0, 1'b1, 101, 100);
    cyc(1'b0, 1'b1, 102, 100);
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", 32'({in_ball, near_ball, hit_id, ball_color}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_sx = '1; m_sy = '1;
    idle(4);
    cyc(1'b0, 1'b1, 100, 100);
    idle(4);

    // Overlap frame
    set_ball(0, 100, 100);
    set_ball(1, 110, 100);
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 105, 100);
    cyc(1'b0, 1'b1, 112, 100);
    idle(4);
    chk("contact_live", 32'(contact), 32'd1);
    chk("contact_frame_prev", 32'(contact_frame), 32'd0);
    set_ball(1, 300, 300);
    cyc(1'b1, 1'b0, 0, 0);
    chk("contact_frame_rot", 32'(contact_frame), 32'd1);
    chk("contact_clear", 32'(contact), 32'd0);
    cyc(1'b0, 1'b1, 105, 100);
    cyc(1'b0, 1'b1, 300, 310);
    idle(4);
    chk("contact_none", 32'(contact), 32'd0);
    cyc(1'b1, 1'b0, 0, 0);
    chk("contact_frame_clear", 32'(contact_frame), 32'd0);

    // Double buffering: position change ignored until frame_start
    set_ball(0, 300, 100);
    cyc(1'b0, 1'b1, 100, 100);
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 100, 100);
    cyc(1'b0, 1'b1, 300, 100);
    set_ball(0, 100, 1024 + 100);
    cyc(1'b1, 1'b1, 300, 100);
    cyc(1'b0, 1'b1, 100, 100);
    idle(4);

    // Randomised pixels, sporadic bubbles and back-to-back frame starts
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int b = 0; b < NB; b++)
          set_ball(b, (($urandom_range(0, 7) == 0) ? 1024 : 0) + int'($urandom_range(90, 130)),
                   int'($urandom_range(90, 130)));
        cyc(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(70, 150)), int'($urandom_range(70, 150)));
      end else begin
        cyc(1'b0, 1'($urandom_range(0, 3) != 0), int'($urandom_range(70, 150)),
            (($urandom_range(0, 15) == 0) ? 1024 : 0) + int'($urandom_range(70, 150)));
      end
    end
    idle(5);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
